sad_search_engine: RTL and testbench
====================================

Name: sad_search_engine

Overview:
Parametrised full-search block-matching motion estimator for the video datapath. It finds the best match for a BLK×BLK reference block inside a 2BLK×2BLK search window, where BLK = 2^BLK_LOG2. It reads both pixel memories itself over synchronous one-cycle-latency read ports and accumulates a saturating SAD for each candidate displacement. It reports the minimum SAD and its signed motion vector. This block supersedes the fixed 16-PE, 8-bit-SAD engine; it adds a run-time early-termination mode and a start/busy/done handshake.

Parameters:
BLK_LOG2, 4, log2 of block edge; BLK = 2^BLK_LOG2.
PIX_W, 8, pixel width (unsigned).
SAD_W, 16, SAD accumulator and result width; saturating.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only when busy=0
early_term_en  in  1  sampled with start; enables candidate abort
AddressR  out  2*BLK_LOG2  reference read address, y*BLK+x
R  in  PIX_W  reference data; valid one cycle after AddressR
AddressS  out  2*BLK_LOG2+2  search read address, (dy+y)*2BLK+(dx+x)
S  in  PIX_W  search data; valid one cycle after AddressS
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when results are final
bestDistance  out  SAD_W  minimum SAD found
motionX  out  BLK_LOG2  signed dx-BLK/2, two's complement
motionY  out  BLK_LOG2  signed dy-BLK/2, two's complement

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - busy=0, done=0, AddressR=0, AddressS=0.
  - bestDistance=all ones; motionX=0, motionY=0.
  - An aborted search produces no done.
- FSM states: IDLE, SCAN, LAST, CMP, FIN.
- IDLE, start=1:
  - Latch early_term_en.
  - bestDistance<=all ones; dx=dy=0; pixel index k=0.
  - Go to SCAN.
- Candidate order: dy outer, dx inner, each 0..BLK-1. Pixel order: y outer, x inner; k=y*BLK+x, 0..BLK²-1.
- SCAN, cycle k:
  - Drive addresses for pixel k.
  - Accumulate pixel k-1 (for k>0): |R-S|, zero-extended to SAD_W.
  - acc clamps at 2^SAD_W-1 and never wraps.
  - Pixel 0 loads acc instead of adding.
  - After k=BLK²-1, go to LAST.
- LAST: accumulate the final pixel; no new address. Go to CMP.
- CMP: update when either holds:
  - this is candidate (0,0), or
  - acc < bestDistance (strict).
  - Update action: bestDistance<=acc, motionX<=dx-BLK/2, motionY<=dy-BLK/2.
  - Ties keep the earlier candidate in scan order.
  - Then advance to the next candidate and return to SCAN, or go to FIN after (BLK-1,BLK-1).
- Early termination (latched enable=1, candidate ≠ (0,0)):
  - Trigger: any accumulate in SCAN/LAST whose post-add acc ≥ bestDistance.
  - The in-flight read is discarded.
  - The next cycle is SCAN k=0 of the next candidate, or FIN if this was the last; CMP is skipped.
- FIN: done=1 for one cycle, busy=0 from that cycle; go to IDLE.
- Results hold until the next accepted start.
- Latency with early termination off: 1 + BLK²·(BLK²+2) cycles from start to done. For BLK_LOG2=2 this is 289 cycles.
- start while busy: ignored. start in the same cycle as done: ignored.
- Address outputs are registered; they hold their last value outside SCAN.

Test Plan:
- BLK_LOG2=2, R=ramp 0..15, S=0xFF except R copied at window offset (3,1), early_term_en=0 -> done exactly 289 cycles after start; bestDistance=0, motionX=2'b01, motionY=2'b11.
- Uniform R=S=7, early_term_en=0 -> all SADs 0; tie rule gives bestDistance=0, motionX=motionY=2'b10 (candidate 0,0).
- SAD_W=8, R=0, S=255 everywhere -> every SAD saturates at 255; bestDistance=255, vector from candidate (0,0); no wrap to small values.
- Same data as the first test with early_term_en=1 -> identical results; done strictly earlier than 289 cycles; non-matching candidates abort without a CMP cycle.
- Assert reset mid-SCAN at cycle 100 -> busy, done and addresses go to 0 and bestDistance to all ones immediately (asynchronous); no done pulse; a new start then completes normally.
- Pulse start at cycle 50 and in the cycle of done -> both ignored; exactly one done pulse and results unchanged.

Source files
------------

// File: rtl/sad_search_engine.sv
// Full-search block-matching motion estimator: scans every BLKxBLK candidate in a
// 2BLKx2BLK window, keeps the minimum saturating SAD and its signed motion vector.
module sad_search_engine #(
  parameter int unsigned BLK_LOG2 = 4,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned SAD_W    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    early_term_en,
  output logic [2*BLK_LOG2-1:0]   AddressR,
  input  logic [PIX_W-1:0]        R,
  output logic [2*BLK_LOG2+1:0]   AddressS,
  input  logic [PIX_W-1:0]        S,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        bestDistance,
  output logic [BLK_LOG2-1:0]     motionX,
  output logic [BLK_LOG2-1:0]     motionY
);

  localparam int unsigned BLK  = 1 << BLK_LOG2;
  localparam int unsigned NPIX = BLK * BLK;
  localparam int unsigned KW   = 2 * BLK_LOG2;
  localparam int unsigned CW   = BLK_LOG2 + 1;
  localparam int unsigned AW   = 2 * CW;
  localparam logic [BLK_LOG2-1:0] HALF   = BLK_LOG2'(BLK / 2);
  localparam logic [KW-1:0]       K_LAST = KW'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, SCAN, LAST, CMP, FIN} state_t;

  state_t                state_q;
  logic                  et_q;
  logic [BLK_LOG2-1:0]   dx_q, dy_q;
  logic [KW-1:0]         k_q;
  logic [SAD_W-1:0]      acc_q, best_q;
  logic [BLK_LOG2-1:0]   mx_q, my_q;
  logic [KW-1:0]         addr_r_q;
  logic [AW-1:0]         addr_s_q;
  logic                  busy_q, done_q;

  logic [PIX_W-1:0]      diff_c;
  logic [SAD_W:0]        sum_c;
  logic [SAD_W-1:0]      acc_nx_c;
  logic                  acc_en_c, first_cand_c, last_cand_c, abort_c, advance_c;
  logic [BLK_LOG2-1:0]   dx_nx_c, dy_nx_c;

  // Window address of pixel k of candidate (dx,dy): row-major in a 2BLK-wide window.
  function automatic logic [AW-1:0] win_addr(input logic [BLK_LOG2-1:0] dx,
                                             input logic [BLK_LOG2-1:0] dy,
                                             input logic [KW-1:0]       k);
    logic [CW-1:0] row, col;
    row = CW'(dy) + CW'(k[KW-1:BLK_LOG2]);
    col = CW'(dx) + CW'(k[BLK_LOG2-1:0]);
    return {row, col};
  endfunction

  assign diff_c   = (R > S) ? R - S : S - R;
  assign sum_c    = {1'b0, acc_q} + (SAD_W+1)'(diff_c);
  // Pixel 0 of a candidate arrives while k=1 and restarts the accumulator.
  assign acc_nx_c = (state_q == SCAN && k_q == KW'(1)) ? SAD_W'(diff_c)
                  : (sum_c[SAD_W] ? '1 : sum_c[SAD_W-1:0]);

  assign acc_en_c     = (state_q == SCAN && k_q != '0) || (state_q == LAST);
  assign first_cand_c = (dx_q == '0) && (dy_q == '0);
  assign last_cand_c  = (&dx_q) && (&dy_q);
  assign abort_c      = et_q && acc_en_c && !first_cand_c && (acc_nx_c >= best_q);
  assign advance_c    = abort_c || (state_q == CMP);
  assign dx_nx_c      = dx_q + BLK_LOG2'(1);
  assign dy_nx_c      = (&dx_q) ? dy_q + BLK_LOG2'(1) : dy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      et_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      best_q   <= '1;
      mx_q     <= '0;
      my_q     <= '0;
      addr_r_q <= '0;
      addr_s_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q  <= SCAN;
          busy_q   <= 1'b1;
          et_q     <= early_term_en;
          best_q   <= '1;
          dx_q     <= '0;
          dy_q     <= '0;
          k_q      <= '0;
          addr_r_q <= '0;
          addr_s_q <= '0;
        end
        SCAN: begin
          if (acc_en_c) acc_q <= acc_nx_c;
          if (k_q == K_LAST) begin
            state_q <= LAST;
          end else begin
            k_q      <= k_q + KW'(1);
            addr_r_q <= k_q + KW'(1);
            addr_s_q <= win_addr(dx_q, dy_q, k_q + KW'(1));
          end
        end
        LAST: begin
          acc_q   <= acc_nx_c;
          state_q <= CMP;
        end
        CMP: if (first_cand_c || acc_q < best_q) begin
          best_q <= acc_q;
          mx_q   <= dx_q - HALF;
          my_q   <= dy_q - HALF;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Move to the next candidate after a compare or an early abort.
      if (advance_c) begin
        if (last_cand_c) begin
          state_q <= FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q  <= SCAN;
          dx_q     <= dx_nx_c;
          dy_q     <= dy_nx_c;
          k_q      <= '0;
          addr_r_q <= '0;
          addr_s_q <= win_addr(dx_nx_c, dy_nx_c, '0);
        end
      end
    end
  end

  assign AddressR     = addr_r_q;
  assign AddressS     = addr_s_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bestDistance = best_q;
  assign motionX      = mx_q;
  assign motionY      = my_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// Bench for sad_search_engine (BLK_LOG2=2): two instances (SAD_W=16 and SAD_W=8)
// share one pair of pixel memories; a reference model feeds a result scoreboard.
module tb_sad_search_engine;

  localparam int N = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start0, start1, et;
  logic [3:0]  ar0, ar1;
  logic [5:0]  as0, as1;
  logic [7:0]  r0, s0, r1, s1;
  logic        busy0, done0, busy1, done1;
  logic [15:0] bd0;
  logic [7:0]  bd1;
  logic [1:0]  mx0, my0, mx1, my1;

  logic [7:0] ref_mem [16];
  logic [7:0] srch_mem [64];

  always @(posedge clock) begin
    r0 <= ref_mem[ar0];
    s0 <= srch_mem[as0];
    r1 <= ref_mem[ar1];
    s1 <= srch_mem[as1];
  end

  sad_search_engine #(.BLK_LOG2(2), .PIX_W(8), .SAD_W(16)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .early_term_en(et),
    .AddressR(ar0), .R(r0), .AddressS(as0), .S(s0),
    .busy(busy0), .done(done0), .bestDistance(bd0), .motionX(mx0), .motionY(my0));

  sad_search_engine #(.BLK_LOG2(2), .PIX_W(8), .SAD_W(8)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .early_term_en(et),
    .AddressR(ar1), .R(r1), .AddressS(as1), .S(s1),
    .busy(busy1), .done(done1), .bestDistance(bd1), .motionX(mx1), .motionY(my1));

  typedef struct {
    int          sel;
    logic [15:0] best;
    logic [1:0]  mx;
    logic [1:0]  my;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total, bad;

  // Straight nested-loop search over the memories, with cycle cost per candidate.
  function automatic exp_t model(input int sel, input bit etv);
    exp_t e;
    int maxv, best, acc, bx, by, cost, lat, d;
    bit ab;
    maxv = sel ? 255 : 65535;
    best = maxv; lat = 1; bx = 0; by = 0;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        acc = 0; ab = 0; cost = N + 2;
        for (int p = 0; p < N; p++) begin
          d = int'(ref_mem[p]) - int'(srch_mem[(dy + p / 4) * 8 + dx + p % 4]);
          if (d < 0) d = -d;
          acc = (acc + d > maxv) ? maxv : acc + d;
          if (etv && (dx != 0 || dy != 0) && acc >= best) begin
            ab = 1; cost = p + 2; break;
          end
        end
        if (!ab && ((dx == 0 && dy == 0) || acc < best)) begin
          best = acc; bx = dx; by = dy;
        end
        lat += cost;
      end
    end
    e.sel = sel; e.best = 16'(best); e.mx = 2'(bx - 2); e.my = 2'(by - 2); e.lat = lat;
    return e;
  endfunction

  task automatic fill_match();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'hFF;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) srch_mem[(1 + y) * 8 + 3 + x] = ref_mem[y * 4 + x];
  endtask

  task automatic fill_const(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < 16; i++) ref_mem[i] = rv;
    for (int i = 0; i < 64; i++) srch_mem[i] = sv;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 64; i++) srch_mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic launch(input int sel, input bit etv);
    sb.push_back(model(sel, etv));
    @(negedge clock);
    et = etv;
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
  endtask

  task automatic wait_done(input int sel, output int n, output bit to);
    n = 0; to = 1'b1;
    while (n < 1000) begin
      @(negedge clock);
      start0 = 1'b0; start1 = 1'b0;
      n++;
      if (((sel != 0) ? done1 : done0) === 1'b1) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done0); end
    total++; if (ar0 !== 4'd0) begin bad++; $display("FAIL rst_addr_r got=%h want=0", ar0); end
    total++; if (as0 !== 6'd0) begin bad++; $display("FAIL rst_addr_s got=%h want=0", as0); end
    total++; if (bd0 !== 16'hFFFF) begin bad++; $display("FAIL rst_best got=%h want=ffff", bd0); end
    total++; if ({mx0, my0} !== 4'b0) begin bad++; $display("FAIL rst_mv got=%b%b want=0000", mx0, my0); end
    total++; if (bd1 !== 8'hFF) begin bad++; $display("FAIL rst_best8 got=%h want=ff", bd1); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_match();
    exp_t e; int n; bit to;
    fill_match();
    launch(0, 1'b0);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL match_timeout got=none want=done"); end
    total++; if (n !== 289) begin bad++; $display("FAIL match_latency got=%0d want=289", n); end
    total++; if (n !== e.lat) begin bad++; $display("FAIL match_lat_model got=%0d want=%0d", n, e.lat); end
    total++; if (bd0 !== 16'd0) begin bad++; $display("FAIL match_best got=%h want=0", bd0); end
    total++; if (mx0 !== 2'b01) begin bad++; $display("FAIL match_mx got=%b want=01", mx0); end
    total++; if (my0 !== 2'b11) begin bad++; $display("FAIL match_my got=%b want=11", my0); end
    total++; if (bd0 !== e.best) begin bad++; $display("FAIL match_best_model got=%h want=%h", bd0, e.best); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL match_busy_at_done got=%b want=0", busy0); end
    @(negedge clock);
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL match_done_pulse got=%b want=0", done0); end
  endtask

  task automatic test_uniform();
    exp_t e; int n; bit to;
    fill_const(8'd7, 8'd7);
    launch(0, 1'b0);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL uni_timeout got=none want=done"); end
    total++; if (bd0 !== 16'd0) begin bad++; $display("FAIL uni_best got=%h want=0", bd0); end
    total++; if ({mx0, my0} !== 4'b1010) begin bad++; $display("FAIL uni_mv got=%b%b want=1010", mx0, my0); end
    total++; if ({mx0, my0} !== {e.mx, e.my}) begin bad++; $display("FAIL uni_mv_model got=%b%b want=%b%b", mx0, my0, e.mx, e.my); end
  endtask

  task automatic test_saturate();
    exp_t e; int n; bit to;
    fill_const(8'd0, 8'd255);
    launch(1, 1'b0);
    wait_done(1, n, to);
    e = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL sat_timeout got=none want=done"); end
    total++; if (bd1 !== 8'hFF) begin bad++; $display("FAIL sat_best got=%h want=ff", bd1); end
    total++; if ({8'h00, bd1} !== e.best) begin bad++; $display("FAIL sat_best_model got=%h want=%h", bd1, e.best); end
    total++; if ({mx1, my1} !== 4'b1010) begin bad++; $display("FAIL sat_mv got=%b%b want=1010", mx1, my1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sat_busy got=%b want=0", busy1); end
  endtask

  task automatic test_early_term();
    exp_t e; int n; bit to;
    fill_match();
    launch(0, 1'b1);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL et_timeout got=none want=done"); end
    total++; if (n >= 289) begin bad++; $display("FAIL et_faster got=%0d want=<289", n); end
    total++; if (n !== e.lat) begin bad++; $display("FAIL et_latency got=%0d want=%0d", n, e.lat); end
    total++; if (bd0 !== 16'd0) begin bad++; $display("FAIL et_best got=%h want=0", bd0); end
    total++; if ({mx0, my0} !== 4'b0111) begin bad++; $display("FAIL et_mv got=%b%b want=0111", mx0, my0); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int n, dones; bit to;
    fill_match();
    launch(0, 1'b0);
    for (int i = 0; i < 100; i++) begin @(negedge clock); start0 = 1'b0; end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy0); end
    #2 reset = 1'b1;
    #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", done0); end
    total++; if ({ar0, as0} !== 10'd0) begin bad++; $display("FAIL mid_addr got=%h/%h want=0/0", ar0, as0); end
    total++; if (bd0 !== 16'hFFFF) begin bad++; $display("FAIL mid_best got=%h want=ffff", bd0); end
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (300) begin @(negedge clock); if (done0 === 1'b1) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dones); end
    launch(0, 1'b0);
    wait_done(0, n, to);
    e = sb.pop_front();
    total++; if (to || n !== 289) begin bad++; $display("FAIL mid_restart_lat got=%0d want=289", n); end
    total++; if ({bd0, mx0, my0} !== {e.best, e.mx, e.my}) begin bad++; $display("FAIL mid_restart_res got=%h %b %b want=%h %b %b", bd0, mx0, my0, e.best, e.mx, e.my); end
  endtask

  task automatic test_ignored_start();
    exp_t e; int n, dones, dn; bit busy_seen;
    fill_match();
    launch(0, 1'b0);
    n = 0; dones = 0; dn = 0; busy_seen = 1'b0;
    while (n < 700) begin
      @(negedge clock);
      start0 = 1'b0;
      n++;
      if (n == 50) start0 = 1'b1;
      if (dones > 0 && busy0 === 1'b1) busy_seen = 1'b1;
      if (done0 === 1'b1) begin
        dones++;
        if (dones == 1) begin dn = n; start0 = 1'b1; end
      end
    end
    e = sb.pop_front();
    total++; if (dones !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", dones); end
    total++; if (dn !== 289) begin bad++; $display("FAIL ign_latency got=%0d want=289", dn); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL ign_restart got=%b want=0", busy_seen); end
    total++; if ({bd0, mx0, my0} !== {e.best, e.mx, e.my}) begin bad++; $display("FAIL ign_hold got=%h %b %b want=%h %b %b", bd0, mx0, my0, e.best, e.mx, e.my); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n, sel; bit to;
    logic [15:0] gbd;
    logic [1:0]  gmx, gmy;
    for (int it = 0; it < 6; it++) begin
      sel = it % 2;
      fill_random();
      if (it == 4) for (int i = 0; i < 16; i++) srch_mem[(2 + i / 4) * 8 + 1 + i % 4] = ref_mem[i];
      launch(sel, 1'((it / 2) % 2));
      wait_done(sel, n, to);
      e = sb.pop_front();
      gbd = (sel != 0) ? {8'h00, bd1} : bd0;
      gmx = (sel != 0) ? mx1 : mx0;
      gmy = (sel != 0) ? my1 : my0;
      total++; if (to) begin bad++; $display("FAIL b2b%0d_timeout got=none want=done", it); end
      total++; if (n !== e.lat) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=%0d", it, n, e.lat); end
      total++; if (gbd !== e.best) begin bad++; $display("FAIL b2b%0d_best got=%h want=%h", it, gbd, e.best); end
      total++; if ({gmx, gmy} !== {e.mx, e.my}) begin bad++; $display("FAIL b2b%0d_mv got=%b%b want=%b%b", it, gmx, gmy, e.mx, e.my); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; et = 1'b0;
    fill_match();
    test_reset();
    test_match();
    test_uniform();
    test_saturate();
    test_early_term();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
